// File: rtl/riscuva_io_pkg.sv
// Shared definitions for the riscuva IO timer block.
// Register offsets from the block's base port address, CTRL/STATUS bit
// indices, timer FSM state encoding and a small address decode helper.
package riscuva_io_pkg;

  // Register offsets from BASE_ADDR
  localparam logic [7:0] OFF_CTRL     = 8'd0;
  localparam logic [7:0] OFF_PRESCALE = 8'd1;
  localparam logic [7:0] OFF_RELOAD   = 8'd2;
  localparam logic [7:0] OFF_COUNT    = 8'd3;
  localparam logic [7:0] OFF_STATUS   = 8'd4;
  localparam logic [7:0] NUM_REGS     = 8'd5;

  // CTRL / STATUS bit indices
  localparam int CTRL_EN    = 0;
  localparam int CTRL_AUTO  = 1;
  localparam int CTRL_IRQEN = 2;
  localparam int STATUS_EXP = 0;

  // Timer FSM states
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_HALT = 2'd2;

  // Offset of a port address from the block base. Wraps modulo 256, so a
  // single unsigned "< NUM_REGS" compare decodes the window even when the
  // base sits near the top of the port space.
  function automatic logic [7:0] reg_offset(input logic [7:0] addr,
                                            input logic [7:0] base);
    return addr - base;
  endfunction

endpackage

// File: rtl/io_prescaler.sv
// Prescaler for io_timer.
// Counts down from the captured period while running and emits a one-cycle
// tick when the count is zero, reloading from period on that tick.
//   clk, reset : system clock, async active-low reset
//   run        : timer is running; when low the counter is cleared
//   load       : restart the count from period (suppresses a same-cycle tick)
//   period     : reload value; tick period is period+1 cycles
//   tick       : one-cycle tick (combinational from the count)
module io_prescaler
  import riscuva_io_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       load,
  input  logic [7:0] period,
  output logic       tick
);

  logic [7:0] cnt;

  // period is only sampled on load or on a tick, so a new PRESCALE value
  // never shortens or stretches the period already in progress.
  assign tick = run && !load && (cnt == 8'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            cnt <= '0;
    else if (load)         cnt <= period;
    else if (!run)         cnt <= '0;
    else if (cnt == 8'd0)  cnt <= period;
    else                   cnt <= cnt - 8'd1;
  end

endmodule

// File: rtl/io_timer.sv
// Programmable interval timer on the CPU port bus.
// Five registers at BASE_ADDR..BASE_ADDR+4: CTRL, PRESCALE, RELOAD, COUNT,
// STATUS. COUNT decrements on each prescaler tick; a tick at COUNT==0 is an
// expiry, which sets STATUS.EXP, optionally reloads (AUTO) or halts, and
// latches an interrupt request when IRQEN is set.
//   clk, reset  : system clock, async active-low reset
//   portAddress : CPU port address
//   wrData      : write data (CPU dataOut)
//   portWrite   : one-cycle write strobe
//   portRead    : read strobe (reads have no side effects)
//   rdData      : combinational read data (CPU dataIn)
//   intReq      : pending interrupt latch
//   intAck      : interrupt acknowledge, clears intReq on the next edge
module io_timer
  import riscuva_io_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] portAddress,
  input  logic [7:0] wrData,
  input  logic       portWrite,
  input  logic       portRead,
  output logic [7:0] rdData,
  output logic       intReq,
  input  logic       intAck
);

  state_t     state;
  logic [2:0] ctrl;
  logic [7:0] prescale;
  logic [7:0] reload;
  logic [7:0] count;
  logic       exp_flag;
  logic       irq_evt;

  logic [7:0] off;
  logic       hit;
  logic       wr_ctrl, wr_prescale, wr_reload, wr_count, wr_status;
  logic       is_run, start, stop;
  logic       pre_load, pre_run, tick, expire;

  logic unused;
  assign unused = portRead;

  // Address decode
  assign off         = reg_offset(portAddress, BASE_ADDR);
  assign hit         = off < NUM_REGS;
  assign wr_ctrl     = portWrite && hit && (off == OFF_CTRL);
  assign wr_prescale = portWrite && hit && (off == OFF_PRESCALE);
  assign wr_reload   = portWrite && hit && (off == OFF_RELOAD);
  assign wr_count    = portWrite && hit && (off == OFF_COUNT);
  assign wr_status   = portWrite && hit && (off == OFF_STATUS);

  // EN=1 while already running only updates CTRL; it does not restart.
  assign is_run = (state == ST_RUN);
  assign start  = wr_ctrl && wrData[CTRL_EN] && !is_run;
  assign stop   = wr_ctrl && !wrData[CTRL_EN];

  // A COUNT write in RUN restarts the prescaler; load masks the tick, so
  // the write wins over a coincident tick and cannot cause an expiry.
  assign pre_load = start || (wr_count && is_run);
  assign pre_run  = is_run && !stop;

  io_prescaler u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .run    (pre_run),
    .load   (pre_load),
    .period (prescale),
    .tick   (tick)
  );

  assign expire = tick && (count == 8'd0);

  // FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            state <= ST_IDLE;
    else if (start)                        state <= ST_RUN;
    else if (stop)                         state <= ST_IDLE;
    else if (expire && !ctrl[CTRL_AUTO])   state <= ST_HALT;
  end

  // Registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl     <= '0;
      prescale <= '0;
      reload   <= '0;
    end else begin
      if (wr_ctrl)     ctrl     <= wrData[2:0];
      if (wr_prescale) prescale <= wrData;
      if (wr_reload)   reload   <= wrData;
    end
  end

  // Counter: a one-shot expiry leaves COUNT at 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             count <= '0;
    else if (start)         count <= reload;
    else if (wr_count)      count <= wrData;
    else if (tick) begin
      if (count != 8'd0)            count <= count - 8'd1;
      else if (ctrl[CTRL_AUTO])     count <= reload;
    end
  end

  // EXP: set wins over a same-cycle write-1-clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               exp_flag <= 1'b0;
    else if (expire)                          exp_flag <= 1'b1;
    else if (wr_status && wrData[STATUS_EXP]) exp_flag <= 1'b0;
  end

  // Interrupt: the expiry is registered first, so intReq rises one cycle
  // after the expiring tick. A set coinciding with intAck keeps intReq high.
  // IRQEN gates only new requests; a pending one waits for intAck.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_evt <= 1'b0;
      intReq  <= 1'b0;
    end else begin
      irq_evt <= expire && ctrl[CTRL_IRQEN];
      if (irq_evt)     intReq <= 1'b1;
      else if (intAck) intReq <= 1'b0;
    end
  end

  // Read mux
  always_comb begin
    rdData = 8'h00;
    if (hit) begin
      case (off)
        OFF_CTRL:     rdData = {5'b0, ctrl};
        OFF_PRESCALE: rdData = prescale;
        OFF_RELOAD:   rdData = reload;
        OFF_COUNT:    rdData = count;
        OFF_STATUS:   rdData = {7'b0, exp_flag};
        default:      rdData = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_io_timer.sv
// Bench for io_timer: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a timing model that
// tracks the next tick as an absolute cycle number.
`timescale 1ns/1ps
module tb_io_timer;

  localparam logic [7:0] BASE = 8'h10;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] portAddress;
  logic [7:0] wrData;
  logic       portWrite;
  logic       portRead;
  logic [7:0] rdData;
  logic       intReq;
  logic       intAck;

  int n_tests = 0;
  int n_fail  = 0;
  int t_edge  = 0;

  io_timer #(.BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .reset       (reset),
    .portAddress (portAddress),
    .wrData      (wrData),
    .portWrite   (portWrite),
    .portRead    (portRead),
    .rdData      (rdData),
    .intReq      (intReq),
    .intAck      (intAck)
  );

  always #10 clk = ~clk;

  // ---------------- reference model ----------------
  logic [2:0] m_ctrl = '0;
  logic [7:0] m_pre = '0, m_rel = '0, m_count = '0;
  bit         m_exp = 0, m_irq = 0, m_irq_pend = 0, m_running = 0;
  longint     cyc = 0, m_next_tick = 0;

  task automatic model_reset();
    m_ctrl = '0; m_pre = '0; m_rel = '0; m_count = '0;
    m_exp = 0; m_irq = 0; m_irq_pend = 0; m_running = 0;
  endtask

  task automatic model_step();
    logic [7:0] o;
    bit wr, wc, wp, wl, wn, ws, tick, expire;
    cyc++;
    o  = portAddress - BASE;
    wr = portWrite && (o < 8'd5);
    wc = wr && o == 8'd0; wp = wr && o == 8'd1; wl = wr && o == 8'd2;
    wn = wr && o == 8'd3; ws = wr && o == 8'd4;
    tick   = m_running && (cyc == m_next_tick) && !wn && !(wc && !wrData[0]);
    expire = tick && (m_count == 8'd0);
    if (m_irq_pend) m_irq = 1; else if (intAck) m_irq = 0;
    m_irq_pend = expire && m_ctrl[2];
    if (expire) m_exp = 1; else if (ws && wrData[0]) m_exp = 0;
    if (wc && wrData[0] && !m_running) begin
      m_running = 1; m_count = m_rel; m_next_tick = cyc + longint'(m_pre) + 1;
    end else if (wc && !wrData[0]) begin
      m_running = 0;
    end else if (wn) begin
      m_count = wrData;
      if (m_running) m_next_tick = cyc + longint'(m_pre) + 1;
    end else if (tick) begin
      m_next_tick = cyc + longint'(m_pre) + 1;
      if (m_count != 8'd0) m_count = m_count - 8'd1;
      else if (m_ctrl[1])  m_count = m_rel;
      else                 m_running = 0;
    end
    if (wc) m_ctrl = wrData[2:0];
    if (wp) m_pre  = wrData;
    if (wl) m_rel  = wrData;
  endtask

  function automatic logic [7:0] model_rd(input logic [7:0] a);
    logic [7:0] o;
    o = a - BASE;
    case (o)
      8'd0: return {5'b0, m_ctrl};
      8'd1: return m_pre;
      8'd2: return m_rel;
      8'd3: return m_count;
      8'd4: return {7'b0, m_exp};
      default: return 8'h00;
    endcase
  endfunction

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) model_reset(); else model_step();
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    n_tests++;
    if (rdData !== model_rd(portAddress)) begin
      n_fail++;
      $display("FAIL rd_data addr=%h got=%h exp=%h t=%0t", portAddress, rdData, model_rd(portAddress), $time);
    end
    n_tests++;
    if (intReq !== m_irq) begin
      n_fail++;
      $display("FAIL int_req got=%b exp=%b t=%0t", intReq, m_irq, $time);
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(negedge clk); #1; t_edge++;
  endtask

  task automatic adv(input int n);
    while (t_edge < n) step();
  endtask

  task automatic wr(input logic [7:0] o, input logic [7:0] d);
    portAddress = BASE + o; wrData = d; portWrite = 1'b1;
    step();
    portWrite = 1'b0;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic rd_chk(input string name, input logic [7:0] o, input logic [7:0] exp);
    portAddress = BASE + o; #1;
    check(name, rdData, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] o, d;
    reset = 1'b0; portAddress = '0; wrData = '0; portWrite = 0; portRead = 0; intAck = 0;
    step(); step();
    check("reset_intreq", {7'b0, intReq}, 8'h00);
    for (int a = 0; a < 5; a++) rd_chk("reset_reg", 8'(a), 8'h00);
    reset = 1'b1;
    step();
    for (int a = 0; a < 5; a++) rd_chk("post_reset_reg", 8'(a), 8'h00);

    // Periodic auto-reload with interrupts: PRESCALE=3, RELOAD=4.
    wr(8'd1, 8'd3); wr(8'd2, 8'd4); wr(8'd0, 8'h07); t_edge = 0;
    adv(19); rd_chk("exp_before_first", 8'd4, 8'h00);
    adv(20); check("irq_at_tick", {7'b0, intReq}, 8'h00);
    rd_chk("exp_first", 8'd4, 8'h01);
    adv(21); check("irq_rise_21", {7'b0, intReq}, 8'h01);
    intAck = 1; adv(22); intAck = 0;
    check("irq_acked", {7'b0, intReq}, 8'h00);
    adv(40); check("irq_before_41", {7'b0, intReq}, 8'h00);
    adv(41); check("irq_rise_41", {7'b0, intReq}, 8'h01);

    // Ack coincident with a new request: stays pending.
    adv(60); intAck = 1; adv(61); intAck = 0;
    check("irq_ack_vs_set", {7'b0, intReq}, 8'h01);
    adv(63); check("irq_still_set", {7'b0, intReq}, 8'h01);
    intAck = 1; adv(64); intAck = 0;
    check("irq_lone_ack", {7'b0, intReq}, 8'h00);

    // STATUS clear coincident with expiry at edge 80: set wins.
    adv(79); portAddress = BASE + 8'd4; wrData = 8'h01; portWrite = 1;
    adv(80); portWrite = 0;
    rd_chk("exp_set_wins", 8'd4, 8'h01);
    portAddress = BASE + 8'd4; wrData = 8'h01; portWrite = 1;
    adv(81); portWrite = 0;
    rd_chk("exp_cleared", 8'd4, 8'h00);
    wr(8'd0, 8'h00);

    // One-shot: RELOAD=2, PRESCALE=0, CTRL=05.
    wr(8'd2, 8'd2); wr(8'd1, 8'd0); wr(8'd0, 8'h05); t_edge = 0;
    adv(2); rd_chk("oneshot_exp_2", 8'd4, 8'h00);
    rd_chk("oneshot_cnt_2", 8'd3, 8'h00);
    adv(3); rd_chk("oneshot_exp_3", 8'd4, 8'h01);
    rd_chk("oneshot_cnt_3", 8'd3, 8'h00);
    portAddress = BASE + 8'd4; wrData = 8'h01; portWrite = 1;
    adv(4); portWrite = 0;
    adv(12); rd_chk("oneshot_no_more", 8'd4, 8'h00);
    rd_chk("oneshot_cnt_held", 8'd3, 8'h00);

    // COUNT write coincident with a tick at COUNT=0 (edge 4).
    wr(8'd1, 8'd1); wr(8'd2, 8'd1); wr(8'd0, 8'h01); t_edge = 0;
    adv(3); portAddress = BASE + 8'd3; wrData = 8'h09; portWrite = 1;
    adv(4); portWrite = 0;
    rd_chk("cnt_write_wins", 8'd3, 8'h09);
    rd_chk("cnt_write_no_exp", 8'd4, 8'h00);
    adv(5); rd_chk("cnt_held_5", 8'd3, 8'h09);
    adv(6); rd_chk("cnt_tick_6", 8'd3, 8'h08);

    // Async reset mid-run with intReq pending.
    wr(8'd0, 8'h00); wr(8'd1, 8'd0); wr(8'd2, 8'd0); wr(8'd0, 8'h07); t_edge = 0;
    adv(3); check("irq_before_reset", {7'b0, intReq}, 8'h01);
    #1 reset = 1'b0;
    #0.5 check("irq_async_clear", {7'b0, intReq}, 8'h00);
    for (int a = 0; a < 6; a++) rd_chk("async_reset_reg", 8'(a), 8'h00);
    step();
    reset = 1'b1;
    step();

    // Randomized phase.
    for (int i = 0; i < 4000; i++) begin
      portWrite = 0;
      intAck = ($urandom_range(0, 7) == 0);
      o = 8'($urandom_range(0, 6));
      portAddress = ($urandom_range(0, 15) == 0) ? 8'($urandom) : BASE + o;
      if ($urandom_range(0, 4) == 0) begin
        portAddress = BASE + o;
        case (o)
          8'd0: begin d = 8'($urandom_range(0, 255)); if ($urandom_range(0, 3) != 0) d[0] = 1'b1; end
          8'd1: d = 8'($urandom_range(0, 3));
          8'd2, 8'd3: d = 8'($urandom_range(0, 5));
          default: d = 8'($urandom);
        endcase
        wrData = d; portWrite = 1;
      end
      if ($urandom_range(0, 699) == 0) begin
        reset = 1'b0; step(); reset = 1'b1;
      end
      step();
    end
    portWrite = 0; intAck = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/io_timer.md
IO_TIMER -- requirements
Module: io_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'h10, meaning the port address of register offset 0 (five consecutive addresses are used).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port portAddress, input, 8, the CPU port address.
REQ-005 SHALL have port wrData, input, 8, write data, connected to CPU dataOut.
REQ-006 SHALL have port portWrite, input, 1, a one-cycle CPU write strobe.
REQ-007 SHALL have port portRead, input, 1, the CPU read strobe (informational; reads have no side effects).
REQ-008 SHALL have port rdData, output, 8, read data, connected to CPU dataIn.
REQ-009 SHALL have port intReq, output, 1, interrupt request to the CPU.
REQ-010 SHALL have port intAck, input, 1, interrupt acknowledge from the CPU.

Function
REQ-011 SHALL decode the following register offsets from BASE_ADDR:
- +0 CTRL: bit0 EN, bit1 AUTO, bit2 IRQEN; bits 7:3 read 0.
- +1 PRESCALE.
- +2 RELOAD.
- +3 COUNT: a write loads the counter.
- +4 STATUS: bit0 EXP; a write of 1 to bit0 clears it.
REQ-012 SHALL drive rdData combinationally from portAddress; any address outside BASE_ADDR..BASE_ADDR+4 reads 8'h00.
REQ-013 SHALL implement FSM states IDLE, RUN and HALT.
REQ-014 SHALL go IDLE->RUN on the edge that captures a CTRL write with EN=1, and at that edge load COUNT<=RELOAD and load the prescaler with PRESCALE.
REQ-015 SHALL go RUN->IDLE on any CTRL write with EN=0; HALT->IDLE likewise; COUNT is retained and the prescaler is cleared.
REQ-016 SHALL, in RUN, decrement the prescaler every cycle and generate a tick when it reaches 0, reloading it with PRESCALE; tick period is PRESCALE+1 cycles.
REQ-017 SHALL, on a tick with COUNT!=0, decrement COUNT.
REQ-018 SHALL, on a tick with COUNT==0, signal an expiry: set EXP; if AUTO=1, set COUNT<=RELOAD and stay in RUN; otherwise go to HALT with COUNT=0.
REQ-019 SHALL give an expiry period of (RELOAD+1)*(PRESCALE+1) cycles; PRESCALE=0 ticks every cycle.
REQ-020 SHALL, in HALT, generate no ticks; a CTRL write with EN=1 restarts the timer as in REQ-014.
REQ-021 SHALL, on a write to COUNT in RUN, load COUNT and restart the prescaler from PRESCALE; the write wins over a same-cycle tick and no expiry occurs that cycle.
REQ-022 SHALL keep EXP set if an expiry and a write-1-clear of STATUS occur in the same cycle (set wins).
REQ-023 SHALL set pending interrupt latch intReq on any expiry while IRQEN=1, registered, so intReq rises one cycle after the tick.
REQ-024 SHALL clear intReq on the edge after intAck=1; if an expiry with IRQEN=1 occurs in the same cycle as intAck, intReq stays 1.
REQ-025 SHALL NOT clear an already-pending intReq when IRQEN is cleared; intAck alone clears it.
REQ-026 SHALL make writes to PRESCALE and RELOAD take effect at the next prescaler or COUNT reload, never mid-period.

Reset
REQ-027 SHALL, while reset=0, immediately force: state IDLE; CTRL, PRESCALE, RELOAD, COUNT, prescaler, EXP = 0; intReq=0.
REQ-028 SHALL, after reset release, leave rdData reflecting the reset register values (all 8'h00).
REQ-029 SHALL, on reset mid-count, discard any pending expiry or interrupt with no glitch on intReq.

Structure
REQ-030 SHALL place register offsets, CTRL bit indices and the state enum in shared package riscuva_io_pkg.
REQ-031 SHALL implement the prescaler as sub-module io_prescaler (inputs: run, load, period; output: one-cycle tick).

Verification
REQ-032 SHALL cover: PRESCALE=3, RELOAD=4, CTRL=8'h07 -> intReq rises 21 cycles after the CTRL write edge (expiry tick at cycle 20, latch +1), then again every 20 cycles.
REQ-033 SHALL cover: CTRL=8'h05 (one-shot), RELOAD=2, PRESCALE=0 -> EXP=1 after 3 cycles, state HALT, COUNT reads 8'h00, no further expiries.
REQ-034 SHALL cover: intAck pulsed in the exact cycle of a second expiry -> intReq remains 1; a later lone intAck -> intReq=0 next cycle.
REQ-035 SHALL cover: STATUS write 8'h01 coincident with expiry -> EXP reads 1; a later STATUS write 8'h01 -> EXP reads 0.
REQ-036 SHALL cover: COUNT write 8'h09 coincident with a tick at COUNT=0 -> no expiry, COUNT reads 8'h09 next cycle.
REQ-037 SHALL cover: reset asserted mid-RUN with intReq=1 -> intReq=0 and all registers read 8'h00 without waiting for a clock edge; read of BASE_ADDR+5 -> 8'h00.
